viterbi_ber_checker: RTL and testbench

//  Receive-end checker for the Viterbi link. Holds reference (pre-encoder) bits in a FIFO and pops one per

---
 rtl/viterbi_ber_checker.sv | 178 +++++++++++++++++
 tb/tb_viterbi_ber_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ber_checker.sv
// Receive-end BER checker: reference-bit FIFO, saturating bit/error/burst counters, lock FSM.
// Optional first-error capture ports are enabled by defining BER_FIRST_ERR_EN.
module viterbi_ber_checker #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             ref_valid_i,
    input  logic             ref_bit_i,
    input  logic             dec_valid_i,
    input  logic             dec_bit_i,
    output logic [CNT_W-1:0] bit_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] burst_max_o,
    output logic             err_flag_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             locked_o
`ifdef BER_FIRST_ERR_EN
    ,
    output logic             first_err_vld_o,
    output logic [CNT_W-1:0] first_err_idx_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_burst_max;
    logic [CNT_W-1:0] r_run;
    logic             r_err_flag;
    logic             r_overflow;
    logic             r_underflow;
    state_t           r_state;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_run_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_mism;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = dec_valid_i && !w_empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_push  = ref_valid_i && (!w_full || w_pop);
    assign w_mism  = r_mem[r_rd_ptr[AW-1:0]] ^ dec_bit_i;

    always_ff @(posedge clk) begin
        if (w_push && !clear_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= ref_bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (clear_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_pop) begin
            case (r_state)
                S_BURST: begin
                    if (w_mism) begin
                        w_run_nxt = (r_run == '1) ? r_run : r_run + CNT_W'(1);
                    end else begin
                        w_state_nxt = S_RUN;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = w_mism ? S_BURST : S_RUN;
                    w_run_nxt   = w_mism ? CNT_W'(1) : '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_burst_max <= '0;
            r_run       <= '0;
            r_err_flag  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_burst_max <= '0;
            r_run       <= '0;
            r_err_flag  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_err_flag <= w_pop && w_mism;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (ref_valid_i && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (dec_valid_i && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_run    <= w_run_nxt;
                if (r_bit_cnt != '1) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                if (w_mism && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                if (w_run_nxt > r_burst_max) begin
                    r_burst_max <= w_run_nxt;
                end
            end
        end
    end

`ifdef BER_FIRST_ERR_EN
    logic             r_first_vld;
    logic [CNT_W-1:0] r_first_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else if (clear_i) begin
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else if (w_pop && w_mism && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_idx <= r_bit_cnt;
        end
    end

    assign first_err_vld_o = r_first_vld;
    assign first_err_idx_o = r_first_idx;
`endif

    assign bit_count_o = r_bit_cnt;
    assign err_count_o = r_err_cnt;
    assign burst_max_o = r_burst_max;
    assign err_flag_o  = r_err_flag;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
    assign locked_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench for viterbi_ber_checker: a queue-based reference model predicts every cycle's outputs.
module tb_viterbi_ber_checker;

    localparam int DEPTH = 16;
    localparam int CNT_W = 7;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear_i = 1'b0;
    logic             ref_valid_i = 1'b0;
    logic             ref_bit_i = 1'b0;
    logic             dec_valid_i = 1'b0;
    logic             dec_bit_i = 1'b0;
    logic [CNT_W-1:0] bit_count_o;
    logic [CNT_W-1:0] err_count_o;
    logic [CNT_W-1:0] burst_max_o;
    logic             err_flag_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             locked_o;
`ifdef BER_FIRST_ERR_EN
    logic             first_err_vld_o;
    logic [CNT_W-1:0] first_err_idx_o;
`endif

    viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
        .bit_count_o(bit_count_o), .err_count_o(err_count_o), .burst_max_o(burst_max_o),
        .err_flag_o(err_flag_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
        .locked_o(locked_o)
`ifdef BER_FIRST_ERR_EN
        , .first_err_vld_o(first_err_vld_o), .first_err_idx_o(first_err_idx_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int bits; int errs; int bmax; int fidx;
        bit flag; bit ovf; bit unf; bit lck; bit fvld;
    } exp_t;

    exp_t exp_q[$];
    bit   m_q[$];
    int   m_bits, m_errs, m_run, m_bmax, m_fidx;
    bit   m_flag, m_ovf, m_unf, m_seen, m_fvld;
    int   checks = 0;
    int   errors = 0;

    function automatic int sat_inc(input int x);
        return (x >= SAT) ? SAT : x + 1;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_bits = 0; m_errs = 0; m_run = 0; m_bmax = 0; m_fidx = 0;
        m_flag = 0; m_ovf = 0; m_unf = 0; m_seen = 0; m_fvld = 0;
    endfunction

    // Run length = number of consecutive mismatching pops ending at the latest pop.
    function automatic void model_step(input bit rv, input bit rb, input bit dv, input bit db);
        bit pop, push, mism, b;
        pop  = dv && (m_q.size() > 0);
        push = rv && ((m_q.size() < DEPTH) || pop);
        if (dv && m_q.size() == 0) m_unf = 1;
        if (rv && !push) m_ovf = 1;
        m_flag = 0;
        if (pop) begin
            b    = m_q.pop_front();
            mism = b ^ db;
            if (mism && !m_fvld) begin
                m_fvld = 1;
                m_fidx = m_bits;
            end
            m_bits = sat_inc(m_bits);
            if (mism) m_errs = sat_inc(m_errs);
            m_run  = mism ? sat_inc(m_run) : 0;
            m_bmax = (m_run > m_bmax) ? m_run : m_bmax;
            m_flag = mism;
            m_seen = 1;
        end
        if (push) m_q.push_back(rb);
    endfunction

    task automatic cycle(input bit rstn, input bit clr, input bit rv, input bit rb,
                         input bit dv, input bit db);
        exp_t e;
        @(negedge clk);
        rst = rstn; clear_i = clr;
        ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db;
        if (!rstn || clr) model_clear();
        else model_step(rv, rb, dv, db);
        e.bits = m_bits; e.errs = m_errs; e.bmax = m_bmax; e.fidx = m_fidx;
        e.flag = m_flag; e.ovf = m_ovf; e.unf = m_unf; e.lck = m_seen; e.fvld = m_fvld;
        exp_q.push_back(e);
    endtask

    // Decoded bit is the model's head-of-FIFO reference, optionally inverted.
    task automatic xfer(input bit rv, input bit dv, input bit inj);
        bit rb, db;
        rb = 1'($urandom);
        db = ((m_q.size() > 0) ? m_q[0] : 1'($urandom)) ^ inj;
        cycle(1'b1, 1'b0, rv, rb, dv, db);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bit_count", 32'(bit_count_o), 32'(e.bits));
                chk("err_count", 32'(err_count_o), 32'(e.errs));
                chk("burst_max", 32'(burst_max_o), 32'(e.bmax));
                chk("err_flag", 32'(err_flag_o), 32'(e.flag));
                chk("overflow", 32'(overflow_o), 32'(e.ovf));
                chk("underflow", 32'(underflow_o), 32'(e.unf));
                chk("locked", 32'(locked_o), 32'(e.lck));
`ifdef BER_FIRST_ERR_EN
                chk("first_vld", 32'(first_err_vld_o), 32'(e.fvld));
                chk("first_idx", 32'(first_err_idx_o), 32'(e.fidx));
`endif
            end
        end
    end

    initial begin : driver
        model_clear();
        #1;
        chk("async_reset_bits", 32'(bit_count_o), 32'd0);
        chk("async_reset_locked", 32'(locked_o), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 100 bits, decoder lagging by 5 cycles, no errors
        for (int i = 0; i < 105; i++) xfer(i < 100, i >= 5, 1'b0);
        idle(2);

        // Same stream with errors on decoded bits 10,11,12 and 40
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 105; i++)
            xfer(i < 100, i >= 5, (i - 5 == 10) || (i - 5 == 11) || (i - 5 == 12) || (i - 5 == 40));
        idle(2);

        // Overflow: DEPTH+1 pushes, then push+pop at full, then drain
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) xfer(1'b1, 1'b0, 1'b0);
        xfer(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) xfer(1'b0, 1'b1, 1'b0);
        idle(1);

        // Underflow with same-cycle push: no bypass, one entry remains
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 1'b1, 1'b0);
        xfer(1'b0, 1'b1, 1'b1);
        idle(1);

        // Saturation: all-error stream exceeding 2**CNT_W-1 compares
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SAT + 20; i++) xfer(1'b1, i > 0, 1'b1);
        xfer(1'b0, 1'b1, 1'b1);
        idle(1);

        // Clear mid-burst with push+pop, then async reset mid-burst
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) xfer(1'b1, i > 1, i > 4);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) xfer(1'b1, i > 1, i > 4);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic with occasional errors and clears
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0)
                cycle(1'b1, 1'b1, 1'(($urandom)), 1'($urandom), 1'($urandom), 1'($urandom));
            else
                xfer($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        idle(2);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
